// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: AES round-step sequencer driving a shared datapath through
// key expansion, initial AddRoundKey, NR rounds (encrypt or decrypt order) and DONE.
module aes_round_sequencer #(
    parameter int KEY_EXP_CYCLES = 24,
    parameter int MIX_COLS       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       aes_start_i,
    input  logic       decrypt_i,
    input  logic [1:0] key_size_i,
    output logic [1:0] select_o,
    output logic [2:0] col_o,
    output logic [3:0] round_o,
    output logic [3:0] key_idx_o,
    output logic       key_en_o,
    output logic       st_en_o,
    output logic       busy_o,
    output logic       aes_done_o
);
    typedef enum logic [2:0] {IDLE, KEYEXP, ARK_INIT, SUB, SHIFT, MIX, ADDK, DONE} state_e;
    localparam logic [5:0] CNT_END = 6'(KEY_EXP_CYCLES - 1);
    localparam logic [2:0] COL_END = 3'(MIX_COLS - 1);
    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [2:0] col_q, col_d;
    logic [3:0] round_q, round_d, nr_q, nr_d;
    logic       last_q, last_d, dec_q, dec_d;
    logic       busy_st;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            round_q <= '0;
            nr_q    <= '0;
            last_q  <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            last_q  <= last_d;
            dec_q   <= dec_d;
        end
    end
    assign busy_st = state_q != IDLE && state_q != DONE;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        round_d = round_q;
        nr_d    = nr_q;
        dec_d   = dec_q;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                col_d   = '0;
                round_d = '0;
                if (aes_start_i) begin
                    state_d = KEYEXP;
                    dec_d   = decrypt_i;
                    nr_d    = key_size_i == 2'b01 ? 4'd12 : key_size_i == 2'b10 ? 4'd14 : 4'd10;
                end
            end
            KEYEXP: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == CNT_END) begin
                    state_d = ARK_INIT;
                    cnt_d   = '0;
                end
            end
            ARK_INIT: begin
                state_d = dec_q ? SHIFT : SUB;
                round_d = 4'd1;
            end
            SUB:   state_d = dec_q ? ADDK : SHIFT;
            SHIFT: state_d = dec_q ? SUB : (last_q ? ADDK : MIX);
            MIX: begin
                col_d = col_q + 3'd1;
                if (col_q == COL_END) begin
                    col_d   = '0;
                    state_d = dec_q ? SHIFT : ADDK;
                    round_d = round_q + 4'(dec_q);
                end
            end
            ADDK: begin
                state_d = last_q ? DONE : (dec_q ? MIX : SUB);
                round_d = last_q ? round_q : round_q + 4'(!dec_q);
            end
            DONE: begin
                if (!aes_start_i) begin
                    state_d = IDLE;
                    round_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                col_d   = '0;
                round_d = '0;
            end
        endcase
        // Dropping the request in any busy state abandons the operation outright.
        if (busy_st && !aes_start_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            col_d   = '0;
            round_d = '0;
        end
        last_d = round_d != 4'd0 && round_d == nr_d;
    end
    always_comb begin
        select_o   = state_q == SUB ? 2'b01 :
                     (state_q == ARK_INIT || state_q == ADDK) ? 2'b10 :
                     state_q == MIX ? 2'b11 : 2'b00;
        col_o      = col_q;
        round_o    = round_q;
        key_idx_o  = (state_q == IDLE || state_q == KEYEXP) ? 4'd0 :
                     dec_q ? nr_q - round_q : round_q;
        key_en_o   = state_q == KEYEXP;
        st_en_o    = busy_st && state_q != KEYEXP;
        busy_o     = busy_st;
        aes_done_o = state_q == DONE;
    end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: scoreboard bench; a round-by-round reference trace is queued per
// run and a negedge monitor compares every busy/done cycle of two differently sized instances.
module tb_aes_round_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] start = '0, dec = '0;
    logic [1:0] ks [2];
    logic [1:0] sel [2];
    logic [2:0] col [2];
    logic [3:0] rnd [2], kidx [2];
    logic [1:0] ken, sten, busy, done;

    typedef struct packed {
        logic [1:0] sel;
        logic [2:0] col;
        logic [3:0] rnd;
        logic [3:0] kidx;
        logic       ken;
        logic       sten;
        logic       done;
    } item_t;

    item_t q0 [$], q1 [$];
    item_t obs_m, exp_m;
    int nchk = 0, nfail = 0;

    aes_round_sequencer u0 (
        .clk(clk), .rst_n(rst_n), .aes_start_i(start[0]), .decrypt_i(dec[0]), .key_size_i(ks[0]),
        .select_o(sel[0]), .col_o(col[0]), .round_o(rnd[0]), .key_idx_o(kidx[0]),
        .key_en_o(ken[0]), .st_en_o(sten[0]), .busy_o(busy[0]), .aes_done_o(done[0])
    );

    aes_round_sequencer #(.KEY_EXP_CYCLES(1), .MIX_COLS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .aes_start_i(start[1]), .decrypt_i(dec[1]), .key_size_i(ks[1]),
        .select_o(sel[1]), .col_o(col[1]), .round_o(rnd[1]), .key_idx_o(kidx[1]),
        .key_en_o(ken[1]), .st_en_o(sten[1]), .busy_o(busy[1]), .aes_done_o(done[1])
    );

    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (busy[i] || done[i]) begin
                obs_m = {sel[i], col[i], rnd[i], kidx[i], ken[i], sten[i], done[i]};
                nchk++;
                if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                    nfail++;
                    $display("FAIL trace%0d: got %h with nothing expected", i, obs_m);
                end else begin
                    exp_m = i == 0 ? q0.pop_front() : q1.pop_front();
                    if (obs_m !== exp_m) begin
                        nfail++;
                        $display("FAIL trace%0d: got %h expected %h", i, obs_m, exp_m);
                    end
                end
            end
        end
    end

    // mode 0: complete run; 1: drop start after trace item cut; 2: pulse reset after item cut
    task automatic run(input int i, input bit d, input logic [1:0] k, input int hold,
                       input int cut, input int mode, input bit scr);
        int kec, mc, nr, kx, n;
        int ord [4];
        item_t tr [$];
        kec = i ? 1 : 24;
        mc  = i ? 1 : 4;
        nr  = k == 2'd1 ? 12 : k == 2'd2 ? 14 : 10;
        if (d) ord = '{0, 1, 2, 3}; else ord = '{1, 0, 3, 2};
        for (int c = 0; c < kec; c++) tr.push_back({2'd0, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0});
        tr.push_back({2'd2, 3'd0, 4'd0, 4'(d ? nr : 0), 1'b0, 1'b1, 1'b0});
        for (int r = 1; r <= nr; r++) begin
            kx = d ? nr - r : r;
            for (int s = 0; s < 4; s++) begin
                if (ord[s] != 3) tr.push_back({2'(ord[s]), 3'd0, 4'(r), 4'(kx), 1'b0, 1'b1, 1'b0});
                else if (r < nr)
                    for (int c = 0; c < mc; c++) tr.push_back({2'd3, 3'(c), 4'(r), 4'(kx), 1'b0, 1'b1, 1'b0});
            end
        end
        n = tr.size();
        if (mode == 0)
            for (int h = 0; h <= hold; h++) tr.push_back({2'd0, 3'd0, 4'(nr), 4'(d ? 0 : nr), 1'b0, 1'b0, 1'b1});
        for (int e = 0; e < tr.size() && (mode == 0 || e <= cut); e++)
            if (i == 0) q0.push_back(tr[e]); else q1.push_back(tr[e]);
        kx = n;
        @(negedge clk);
        dec[i] = d; ks[i] = k; start[i] = 1'b1;
        if (mode == 0) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (scr) begin dec[i] = 1'($urandom); ks[i] = 2'($urandom); end
            end while (!done[i] && n < 400);
            check($sformatf("latency%0d", i), n, kx + 1);
            repeat (hold) @(negedge clk);
            start[i] = 1'b0;
            @(negedge clk);
            check($sformatf("done_release%0d", i), {busy[i], done[i]}, 0);
        end else begin
            repeat (cut + 1) begin
                @(negedge clk);
                if (scr) begin dec[i] = 1'($urandom); ks[i] = 2'($urandom); end
            end
            if (mode == 1) begin
                start[i] = 1'b0;
                @(negedge clk);
                check($sformatf("abort_idle%0d", i), {busy[i], done[i], rnd[i], col[i]}, 0);
            end else begin
                #2 rst_n = 1'b0;
                #1 check("reset_outputs", {sel[i], col[i], rnd[i], kidx[i], ken[i], sten[i], busy[i], done[i]}, 0);
                start[i] = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) @(negedge clk);
                check("post_reset_idle", {busy[i], done[i]}, 0);
            end
        end
        check($sformatf("queue_empty%0d", i), i == 0 ? q0.size() : q1.size(), 0);
    endtask

    initial begin
        ks[0] = 2'd0; ks[1] = 2'd0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++)
            check($sformatf("reset_state%0d", i),
                  {sel[i], col[i], rnd[i], kidx[i], ken[i], sten[i], busy[i], done[i]}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 1'b1, 2'd0, 2, 0, 0, 1'b0);
        run(0, 1'b0, 2'd2, 0, 0, 0, 1'b0);
        run(0, 1'b1, 2'd3, 1, 0, 0, 1'b1);
        run(0, 1'b1, 2'd0, 0, 57, 1, 1'b0);
        run(0, 1'b1, 2'd0, 0, 0, 0, 1'b0);
        run(0, 1'b0, 2'd0, 0, 45, 2, 1'b0);
        run(0, 1'b0, 2'd0, 0, 0, 0, 1'b0);
        run(1, 1'b1, 2'd1, 1, 0, 0, 1'b0);
        run(1, 1'b0, 2'd2, 0, 20, 1, 1'b1);
        for (int t = 0; t < 6; t++)
            run(int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), int'($urandom_range(0, 3)), 0, 0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
